// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time counter.
package stopwatch_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } sw_state_t;

   localparam int              BCD_W    = 4;
   localparam int              N_DIGITS = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the time cascade: counts 0..9 on inc_en and
// raises carry on the increment that rolls it from 9 back to 0.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc_en,
   output logic [BCD_W-1:0] value,
   output logic             carry
);

   assign carry = inc_en && (value == BCD_MAX);

   // Digit register: rolls 9 -> 0 so it never leaves the BCD range.
   always_ff @(posedge clk) begin
      if (rst || clr)
         value <= '0;
      else if (inc_en)
         value <= (value == BCD_MAX) ? '0 : value + 1'b1;
   end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase: prescaler producing 1/100 s ticks, a four-digit BCD
// cascade (SS.hh), a run/lap/pause FSM and the lap freeze latch.
module stopwatch_bcd_counter
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 500000,
   parameter bit WRAP     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        lap_reset,
   output logic [15:0] bcd,
   output logic        running,
   output logic        lap_active,
   output logic        overflow
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   sw_state_t state, next_state;

   logic [PRE_W-1:0]                prescaler;
   logic [N_DIGITS-1:0][BCD_W-1:0]  count;
   logic [N_DIGITS-1:0][BCD_W-1:0]  lap_latch;
   logic [N_DIGITS-1:0]             inc;
   logic [N_DIGITS-1:0]             carry;

   logic counting, tick, at_max, sat, cnt_inc, ovf_evt;
   logic clr_cnt, latch_en;

   assign counting = (state == RUN) || (state == LAP);
   assign tick     = counting && (prescaler == PRE_LAST);
   assign at_max   = (count == {N_DIGITS{BCD_MAX}});
   // Saturating build: the tick at 99.99 is swallowed so the digits hold.
   assign sat      = tick && at_max && !WRAP;
   assign cnt_inc  = tick && !sat;
   assign ovf_evt  = carry[N_DIGITS-1] || sat;

   // Ripple enable: digit i advances when the tick reaches it through
   // every lower digit sitting at 9.
   assign inc = {carry[N_DIGITS-2:0], cnt_inc};

   for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk    (clk),
         .rst    (rst),
         .clr    (clr_cnt),
         .inc_en (inc[i]),
         .value  (count[i]),
         .carry  (carry[i])
      );
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state: start_stop beats saturation, which beats lap_reset.
   always_comb begin
      next_state = state;
      clr_cnt    = 1'b0;
      latch_en   = 1'b0;
      case (state)
         IDLE: begin
            if (start_stop) next_state = RUN;
         end
         RUN: begin
            if (start_stop || sat) next_state = PAUSE;
            else if (lap_reset) begin
               next_state = LAP;
               latch_en   = 1'b1;
            end
         end
         LAP: begin
            if (start_stop || sat) next_state = PAUSE;
            else if (lap_reset)    next_state = RUN;
         end
         PAUSE: begin
            if (start_stop) next_state = RUN;
            else if (lap_reset) begin
               next_state = IDLE;
               clr_cnt    = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Prescaler: runs only while counting and keeps its phase across a pause.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt)
         prescaler <= '0;
      else if (counting)
         prescaler <= tick ? '0 : prescaler + 1'b1;
   end

   // Lap latch captures the live count at the moment lap is pressed.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) lap_latch <= '0;
      else if (latch_en)  lap_latch <= count;
   end

   // Sticky overflow, dropped only by a clear or reset.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) overflow <= 1'b0;
      else if (ovf_evt)   overflow <= 1'b1;
   end

   assign running    = counting;
   assign lap_active = (state == LAP);
   assign bcd        = lap_active ? lap_latch : count;

endmodule
